hdmi_audio_scheduler: RTL and testbench

Single-clock audio scheduler in the pixel domain between the NeoGeo core audio outputs and the HDMI audio packetizer. It generates an exact-average 48 kHz sample strobe from the pixel clock using a fractional accumulator. On each strobe it captures a stereo sample, applying mute if requested, into a small first-word-fall-through (FWFT) FIFO that the packetizer drains by valid/ready handshake. It also measures the Audio Clock Regeneration (ACR) CTS value and pulses it, together with N, once per ACR period.

---
 rtl/hdmi_audio_scheduler.sv | 176 +++++++++++++++++
 tb/tb_hdmi_audio_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_audio_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_audio_scheduler
//  Description : Pixel-domain audio scheduler for the HDMI packetizer.
//                Generates an exact-average sample strobe with a fractional
//                accumulator and queues captured stereo samples in a small
//                FWFT FIFO drained by valid/ready. It also measures the ACR CTS
//                value once per ACR period.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_audio_scheduler #(
  parameter int CLK_HZ     = 74250000,
  parameter int SAMPLE_HZ  = 48000,
  parameter int ACR_N      = 6144,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic [15:0]                   audio_l,
  input  logic [15:0]                   audio_r,
  input  logic                          mute,
  input  logic                          clear_overflow,
  output logic                          sample_tick,
  output logic [31:0]                   audio_sample_word,
  output logic                          audio_sample_valid,
  input  logic                          audio_sample_ready,
  output logic [19:0]                   acr_cts,
  output logic [19:0]                   acr_n,
  output logic                          acr_valid,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                c_acr_samples = ACR_N / 128;
  localparam int                c_aw          = $clog2(FIFO_DEPTH);
  localparam int                c_tw          = $clog2(c_acr_samples) + 1;
  // Accumulator stays below CLK_HZ (< 2^31) and SAMPLE_HZ < CLK_HZ, so the
  // sum always fits in 32 bits.
  localparam logic [31:0]       c_sample_inc  = 32'(SAMPLE_HZ);
  localparam logic [31:0]       c_clk_hz      = 32'(CLK_HZ);
  localparam logic [c_tw-1:0]   c_tick_last   = c_tw'(c_acr_samples - 1);
  localparam logic [c_aw:0]     c_depth       = (c_aw + 1)'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Fractional sample-rate accumulator
  // --------------------------------------------------------------------------
  logic [31:0] r_acc;
  logic        r_tick;
  logic [31:0] w_acc_sum;
  logic        w_wrap;

  assign w_acc_sum = r_acc + c_sample_inc;
  assign w_wrap    = (w_acc_sum >= c_clk_hz);

  // Advance the phase accumulator; the strobe is the registered wrap.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_wrap ? (w_acc_sum - c_clk_hz) : w_acc_sum;
      r_tick <= w_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Sample FIFO (first-word-fall-through)
  // --------------------------------------------------------------------------
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_level;
  logic [31:0]     r_word;
  logic            r_overflow;

  logic            w_valid;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [31:0]     w_din;
  logic [c_aw-1:0] w_rd_next;

  assign w_valid   = (r_level != '0);
  assign w_full    = (r_level == c_depth);
  assign w_pop     = w_valid & audio_sample_ready;
  // A pop on the same edge frees the slot the new sample needs.
  assign w_push    = w_wrap & (~w_full | w_pop);
  assign w_drop    = w_wrap & w_full & ~w_pop;
  assign w_din     = mute ? 32'h0 : {audio_l, audio_r};
  assign w_rd_next = r_rd_ptr + 1'b1;

  // Storage array; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk_pixel) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= w_din;
    end
  end

  // Pointers, level, sticky overflow and the registered head word.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_word     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_next;

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      // A new drop wins over a simultaneous clear.
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;

      // Head word tracks the next head; it holds its last value when empty.
      if (r_level == '0) begin
        if (w_push) r_word <= w_din;
      end else if (w_pop) begin
        if (r_level == (c_aw + 1)'(1)) begin
          if (w_push) r_word <= w_din;
        end else begin
          r_word <= r_mem[w_rd_next];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // ACR CTS measurement
  // --------------------------------------------------------------------------
  logic [19:0]     r_cts_cnt;
  logic [c_tw-1:0] r_tick_cnt;
  logic [19:0]     r_acr_cts;
  logic            r_acr_valid;
  logic            w_acr_end;

  assign w_acr_end = w_wrap & (r_tick_cnt == c_tick_last);

  // Count pixel edges across ACR_N/128 samples and latch the total.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_cts_cnt   <= '0;
      r_tick_cnt  <= '0;
      r_acr_cts   <= '0;
      r_acr_valid <= 1'b0;
    end else begin
      r_acr_valid <= w_acr_end;
      if (w_acr_end) begin
        r_acr_cts  <= r_cts_cnt + 1'b1;
        r_cts_cnt  <= '0;
        r_tick_cnt <= '0;
      end else begin
        r_cts_cnt <= r_cts_cnt + 1'b1;
        if (w_wrap) r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  assign sample_tick        = r_tick;
  assign audio_sample_word  = r_word;
  assign audio_sample_valid = w_valid;
  assign fifo_level         = r_level;
  assign overflow           = r_overflow;
  assign acr_cts            = r_acr_cts;
  assign acr_valid          = r_acr_valid;
  assign acr_n              = 20'(ACR_N);

endmodule
`default_nettype wire

// File: tb/tb_hdmi_audio_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_audio_scheduler
//  Description : Self-checking bench for hdmi_audio_scheduler. Uses a scaled
//                clock ratio (12375 / 8 = 1546.875, same as 74.25 MHz / 48 kHz)
//                so that ACR periods are 12375 edges long.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_audio_scheduler;

  localparam int CLK_HZ     = 12375;
  localparam int SAMPLE_HZ  = 8;
  localparam int ACR_N      = 1024;
  localparam int FIFO_DEPTH = 4;
  localparam int EXP_CTS    = 12375;

  logic        clk_pixel;
  logic        reset;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        mute;
  logic        clear_overflow;
  logic        audio_sample_ready;
  logic        sample_tick;
  logic [31:0] audio_sample_word;
  logic        audio_sample_valid;
  logic [19:0] acr_cts;
  logic [19:0] acr_n;
  logic        acr_valid;
  logic        overflow;
  logic [2:0]  fifo_level;

  hdmi_audio_scheduler #(
    .CLK_HZ     (CLK_HZ),
    .SAMPLE_HZ  (SAMPLE_HZ),
    .ACR_N      (ACR_N),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .audio_l            (audio_l),
    .audio_r            (audio_r),
    .mute               (mute),
    .clear_overflow     (clear_overflow),
    .sample_tick        (sample_tick),
    .audio_sample_word  (audio_sample_word),
    .audio_sample_valid (audio_sample_valid),
    .audio_sample_ready (audio_sample_ready),
    .acr_cts            (acr_cts),
    .acr_n              (acr_n),
    .acr_valid          (acr_valid),
    .overflow           (overflow),
    .fifo_level         (fifo_level)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  int          n_tests;
  int          n_fail;
  int          edge_n;
  int          last_tick_edge;
  int          tick_count;
  int          acr_count;
  int          last_acr_edge;
  logic        exp_ovf;
  logic [31:0] last_dut_pop;
  logic [31:0] sb [$];

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        m;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs [6];

  function automatic bit is_wrap(input int e);
    longint a;
    longint b;
    a = (longint'(e) * SAMPLE_HZ) / CLK_HZ;
    b = (longint'(e - 1) * SAMPLE_HZ) / CLK_HZ;
    return a != b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One clock edge: predict, advance, then compare the outputs.
  task automatic step();
    bit wrap_n;
    bit pop_m;
    bit set_n;
    bit acr_exp;
    edge_n++;
    wrap_n = is_wrap(edge_n);
    pop_m  = (sb.size() != 0) && audio_sample_ready;
    if (pop_m) begin
      last_dut_pop = audio_sample_word;
      chk("popped_word", audio_sample_word, sb.pop_front());
    end
    set_n = 1'b0;
    if (wrap_n) begin
      if (sb.size() < FIFO_DEPTH) sb.push_back(mute ? 32'h0 : {audio_l, audio_r});
      else set_n = 1'b1;
    end
    if (set_n) exp_ovf = 1'b1;
    else if (clear_overflow) exp_ovf = 1'b0;
    acr_exp = wrap_n && ((edge_n % EXP_CTS) == 0);

    @(posedge clk_pixel);
    #1;
    chk("sample_tick", sample_tick, wrap_n);
    chk("valid", audio_sample_valid, sb.size() != 0);
    chk("fifo_level", fifo_level, sb.size());
    chk("overflow", overflow, exp_ovf);
    chk("acr_valid", acr_valid, acr_exp);
    if (acr_exp) begin
      chk("acr_cts", acr_cts, EXP_CTS);
      chk("acr_n", acr_n, ACR_N);
    end
    if (sample_tick) begin
      tick_count++;
      if (last_tick_edge == 0) chk("first_tick_edge", edge_n, 1547);
      else chk("tick_spacing_ok", ((edge_n - last_tick_edge) == 1546) ||
                                  ((edge_n - last_tick_edge) == 1547), 1);
      last_tick_edge = edge_n;
    end
    if (acr_valid) begin
      acr_count++;
      last_acr_edge = edge_n;
    end
  endtask

  task automatic run_to_prewrap();
    while (!is_wrap(edge_n + 1)) step();
  endtask

  task automatic run_to_tick();
    run_to_prewrap();
    step();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_ovf        = 1'b0;
    edge_n         = 0;
    last_tick_edge = 0;
    chk("rst_sample_tick", sample_tick, 0);
    chk("rst_valid", audio_sample_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_acr_valid", acr_valid, 0);
    chk("rst_acr_cts", acr_cts, 0);
    chk("rst_acr_n", acr_n, ACR_N);
    chk("rst_word", audio_sample_word, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; edge_n = 0; last_tick_edge = 0;
    tick_count = 0; acr_count = 0; last_acr_edge = 0;
    exp_ovf = 1'b0; last_dut_pop = '0;
    reset = 1'b1; audio_l = 16'h1234; audio_r = 16'hABCD; mute = 1'b0;
    clear_overflow = 1'b0; audio_sample_ready = 1'b1;

    vecs[0] = '{16'h1234, 16'hABCD, 1'b0, 32'h1234ABCD};
    vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 32'h80007FFF};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 32'h00000000};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 32'h00000000};
    vecs[4] = '{16'h5A5A, 16'hA5A5, 1'b1, 32'h00000000};
    vecs[5] = '{16'hDEAD, 16'hBEEF, 1'b0, 32'hDEADBEEF};

    do_reset(3);

    // Captures with ready held high, first one straight out of reset.
    for (int i = 0; i < 6; i++) begin
      audio_l = vecs[i].l;
      audio_r = vecs[i].r;
      mute    = vecs[i].m;
      run_to_tick();
      step();
      chk($sformatf("vec%0d_word", i), last_dut_pop, vecs[i].exp_word);
    end

    // Two full ACR periods from reset, muted throughout.
    do_reset(1);
    audio_l = 16'h4321; audio_r = 16'h8765; mute = 1'b1;
    tick_count = 0; acr_count = 0;
    repeat (2 * EXP_CTS) step();
    chk("ticks_in_2_periods", tick_count, 16);
    chk("acr_pulses_in_2_periods", acr_count, 2);
    mute = 1'b0;

    // Fill with ready low; the fifth sample is dropped.
    audio_sample_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      audio_l = 16'h1000 + 16'(k);
      audio_r = 16'h2000 + 16'(k);
      run_to_tick();
    end
    chk("full_level", fifo_level, 4);
    chk("full_overflow", overflow, 1);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    chk("cleared_overflow", overflow, 0);

    // Clear and a new drop on the same edge: the drop wins.
    run_to_prewrap();
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    chk("set_beats_clear", overflow, 1);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;

    // Wrap while full coinciding with a pop: push and pop, no overflow.
    run_to_prewrap();
    audio_l = 16'h1006; audio_r = 16'h2006;
    audio_sample_ready = 1'b1;
    step();
    chk("full_pushpop_level", fifo_level, 4);
    chk("full_pushpop_overflow", overflow, 0);
    repeat (4) step();
    chk("drained_last_word", last_dut_pop, 32'h10062006);
    chk("drained_level", fifo_level, 0);

    // Reset mid-period with two samples queued.
    audio_sample_ready = 1'b0;
    run_to_tick();
    run_to_tick();
    repeat (100) step();
    chk("queued_before_reset", fifo_level, 2);
    do_reset(1);
    audio_sample_ready = 1'b1;
    acr_count = 0; last_acr_edge = 0;
    repeat (EXP_CTS) step();
    chk("acr_after_reset_count", acr_count, 1);
    chk("acr_after_reset_edge", last_acr_edge, EXP_CTS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
